// File: rtl/mmio_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_timer: memory-mapped 64-bit cycle counter with a one-shot       |
// | compare interrupt, answering core data-port requests after one wait. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

package mmio_timer_pkg;
  typedef logic [2:0] mem_store_type_t;
endpackage

module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [63:0] TIME_ADDR = 64'hFFFF_001C,
  parameter logic [63:0] ACK_ADDR  = 64'hFFFF_006C,
  parameter int unsigned CYCLE_W   = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  input  mem_store_type_t d_store_type,
  input  logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_ready,
  output logic            hit,
  output logic            timer_interrupt
);

  localparam logic [CYCLE_W-1:0] c_CYCLE_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_sel_time;
  logic                 w_sel_ack;
  logic                 w_is_write;
  logic                 w_time_wr;
  logic                 w_ack_wr;
  logic                 w_match;
  logic [CYCLE_W-1:0]   r_cycle;
  logic [CYCLE_W-1:0]   r_compare;
  logic                 r_armed;
  logic                 r_pending;
  logic [63:0]          r_rdata;

  assign w_sel_time = (d_addr == TIME_ADDR);
  assign w_sel_ack  = (d_addr == ACK_ADDR);
  assign hit        = d_valid && (w_sel_time || w_sel_ack);
  assign w_is_write = (d_store_type != '0);
  assign w_time_wr  = w_accept && w_is_write && w_sel_time;
  assign w_ack_wr   = w_accept && w_is_write && w_sel_ack;
  assign w_match    = r_armed && (r_cycle == r_compare);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The core keeps the same request on the bus during RESP, so d_valid is
  // deliberately ignored there to avoid accepting it twice.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hit) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + c_CYCLE_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_compare <= '0;
    end else if (w_time_wr) begin
      r_compare <= d_wdata[CYCLE_W-1:0];
    end
  end

  // A compare write re-arms even if the old compare matched this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_time_wr) begin
      r_armed <= 1'b1;
    end else if (w_match) begin
      r_armed <= 1'b0;
    end
  end

  // Set beats clear so a match coinciding with an ACK is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_match) begin
      r_pending <= 1'b1;
    end else if (w_ack_wr) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_accept) begin
      if (!w_is_write && w_sel_time) begin
        r_rdata <= 64'(r_cycle);
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign d_ready         = (r_state == S_RESP);
  assign d_rdata         = r_rdata;
  assign timer_interrupt = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// Directed bench for mmio_timer: a full-width instance for the main behaviour
// and an 8-bit-counter instance to reach the counter wrap quickly.

module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam logic [63:0] TA  = 64'hFFFF_001C;
  localparam logic [63:0] AA  = 64'hFFFF_006C;
  localparam logic [63:0] BAD = 64'hFFFF_0020;

  logic            clock = 1'b0;
  logic            reset;
  logic [63:0]     d_addr, d_wdata, d_rdata;
  mem_store_type_t d_store_type;
  logic            d_valid, d_ready, hit, timer_interrupt;

  logic [63:0]     a8, w8, rdata8;
  mem_store_type_t st8;
  logic            v8, ready8, hit8, intr8;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] mc;
  logic [7:0]  mc8;
  logic [63:0] m0;

  always #5 clock = ~clock;

  mmio_timer dut (
    .clock(clock), .reset(reset), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_store_type(d_store_type), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_ready(d_ready), .hit(hit), .timer_interrupt(timer_interrupt)
  );

  mmio_timer #(.CYCLE_W(8)) dut8 (
    .clock(clock), .reset(reset), .d_addr(a8), .d_wdata(w8),
    .d_store_type(st8), .d_valid(v8), .d_rdata(rdata8),
    .d_ready(ready8), .hit(hit8), .timer_interrupt(intr8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mc/mc8 track the value the DUT counters hold after each edge.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      mc  = 64'd0;
      mc8 = 8'd0;
    end else begin
      mc  = mc + 64'd1;
      mc8 = mc8 + 8'd1;
    end
    #1;
  endtask

  task automatic wait_until(input logic [63:0] t);
    int n = 0;
    while (mc != t && n < 1000) begin
      tick();
      n++;
    end
    if (mc != t) chk("wait_bound", mc, t);
  endtask

  task automatic wait8(input logic [7:0] t);
    int n = 0;
    while (mc8 != t && n < 600) begin
      tick();
      n++;
    end
    if (mc8 != t) chk("wait8_bound", 64'(mc8), 64'(t));
  endtask

  task automatic req(input logic [63:0] a, input logic [63:0] w, input bit wr);
    d_valid      = 1'b1;
    d_addr       = a;
    d_wdata      = w;
    d_store_type = wr ? 3'd3 : 3'd0;
  endtask

  task automatic idle();
    d_valid      = 1'b0;
    d_addr       = 64'd0;
    d_wdata      = 64'd0;
    d_store_type = 3'd0;
  endtask

  task automatic req8(input logic [63:0] a, input logic [63:0] w, input bit wr);
    v8  = 1'b1;
    a8  = a;
    w8  = w;
    st8 = wr ? 3'd3 : 3'd0;
  endtask

  task automatic idle8();
    v8  = 1'b0;
    a8  = 64'd0;
    w8  = 64'd0;
    st8 = 3'd0;
  endtask

  // Full write access on the main instance: accept edge, response edge, release.
  task automatic write_main(input logic [63:0] a, input logic [63:0] w);
    req(a, w, 1'b1);
    tick();
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mc    = 64'd0;
    mc8   = 8'd0;
    idle();
    idle8();
    tick();
    tick();
    chk("rst_ready", 64'(d_ready), 64'd0);
    chk("rst_rdata", d_rdata, 64'd0);
    chk("rst_intr", 64'(timer_interrupt), 64'd0);
    chk("rst_hit_novalid", 64'(hit), 64'd0);
    reset = 1'b0;

    // Read accepted at cycle 5
    wait_until(64'd5);
    req(TA, 64'd0, 1'b0);
    #1;
    chk("hit_time", 64'(hit), 64'd1);
    tick();
    chk("rd5_ready", 64'(d_ready), 64'd1);
    chk("rd5_rdata", d_rdata, 64'd5);
    tick();
    idle();
    chk("rd5_ready_drop", 64'(d_ready), 64'd0);
    tick();
    chk("rd5_ready_stay0", 64'(d_ready), 64'd0);

    // Compare 20 written at cycle 10
    wait_until(64'd10);
    req(TA, 64'd20, 1'b1);
    tick();
    chk("wr_ready", 64'(d_ready), 64'd1);
    chk("wr_rdata", d_rdata, 64'd0);
    tick();
    idle();
    chk("wr_ready_drop", 64'(d_ready), 64'd0);
    wait_until(64'd20);
    chk("intr_before_match", 64'(timer_interrupt), 64'd0);
    tick();
    chk("intr_rise", 64'(timer_interrupt), 64'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("intr_hold", 64'(timer_interrupt), 64'd1);
    end
    req(AA, 64'd0, 1'b1);
    #1;
    chk("hit_ack", 64'(hit), 64'd1);
    tick();
    chk("ack_clear", 64'(timer_interrupt), 64'd0);
    chk("ack_ready", 64'(d_ready), 64'd1);
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("oneshot_quiet", 64'(timer_interrupt), 64'd0);
    end

    // Unselected address must not touch compare or pending
    m0 = mc;
    write_main(TA, m0 + 64'd30);
    req(BAD, mc + 64'd3, 1'b1);
    #1;
    chk("hit_bad", 64'(hit), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bad_no_ready", 64'(d_ready), 64'd0);
    end
    req(BAD, 64'd0, 1'b0);
    tick();
    chk("bad_rd_no_ready", 64'(d_ready), 64'd0);
    idle();
    wait_until(m0 + 64'd30);
    chk("bad_no_fire", 64'(timer_interrupt), 64'd0);
    tick();
    chk("orig_compare_fire", 64'(timer_interrupt), 64'd1);
    req(BAD, 64'd0, 1'b1);
    tick();
    tick();
    chk("bad_keeps_pending", 64'(timer_interrupt), 64'd1);
    idle();
    req(AA, 64'd0, 1'b1);
    tick();
    chk("ack2_clear", 64'(timer_interrupt), 64'd0);
    tick();
    idle();

    // ACK accepted in the match cycle: set wins
    m0 = mc + 64'd10;
    write_main(TA, m0);
    wait_until(m0);
    req(AA, 64'd0, 1'b1);
    tick();
    chk("ack_vs_match", 64'(timer_interrupt), 64'd1);
    chk("ack_vs_match_ready", 64'(d_ready), 64'd1);
    tick();
    idle();
    chk("ack_vs_match_hold", 64'(timer_interrupt), 64'd1);
    req(AA, 64'd0, 1'b1);
    tick();
    chk("ack3_clear", 64'(timer_interrupt), 64'd0);
    tick();
    idle();

    // Compare write in the match cycle: old compare fires, new one re-arms
    m0 = mc + 64'd10;
    write_main(TA, m0);
    wait_until(m0);
    req(TA, m0 + 64'd8, 1'b1);
    tick();
    chk("wr_vs_match_fire", 64'(timer_interrupt), 64'd1);
    tick();
    idle();
    req(AA, 64'd0, 1'b1);
    tick();
    chk("ack4_clear", 64'(timer_interrupt), 64'd0);
    tick();
    idle();
    wait_until(m0 + 64'd8);
    chk("rearm_quiet", 64'(timer_interrupt), 64'd0);
    tick();
    chk("rearm_fire", 64'(timer_interrupt), 64'd1);

    // Back-to-back reads, then reset during RESP
    m0 = mc;
    req(TA, 64'd0, 1'b0);
    tick();
    chk("b2b_ready1", 64'(d_ready), 64'd1);
    chk("b2b_rdata1", d_rdata, m0);
    tick();
    chk("b2b_gap", 64'(d_ready), 64'd0);
    tick();
    chk("b2b_ready2", 64'(d_ready), 64'd1);
    chk("b2b_rdata2", d_rdata, m0 + 64'd2);
    reset = 1'b1;
    idle();
    tick();
    chk("rstresp_ready", 64'(d_ready), 64'd0);
    chk("rstresp_rdata", d_rdata, 64'd0);
    chk("rstresp_intr", 64'(timer_interrupt), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstresp_disarmed", 64'(timer_interrupt), 64'd0);
    end
    wait_until(64'd8);
    req(TA, 64'd0, 1'b0);
    tick();
    chk("post_rst_rdata", d_rdata, 64'd8);
    tick();
    idle();

    // Wrap on the 8-bit counter instance
    req8(TA, 64'd1, 1'b1);
    #1;
    chk("hit8", 64'(hit8), 64'd1);
    tick();
    chk("w8_ready", 64'(ready8), 64'd1);
    tick();
    idle8();
    wait8(8'd254);
    chk("past_compare_quiet", 64'(intr8), 64'd0);
    req8(TA, 64'd0, 1'b0);
    tick();
    chk("rd254_ready", 64'(ready8), 64'd1);
    chk("rd254_rdata", rdata8, 64'd254);
    tick();
    chk("rd8_gap", 64'(ready8), 64'd0);
    tick();
    chk("wrap_ready", 64'(ready8), 64'd1);
    chk("wrap_to_zero", rdata8, 64'd0);
    chk("wrap_before_match", 64'(intr8), 64'd0);
    tick();
    idle8();
    chk("wrap_match", 64'(intr8), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped cycle timer on the core's peripheral data port, directly downstream of the core's data interface. It decodes requests from the core's MEM stage (`d_addr`, `d_wdata`, `d_store_type`, `d_valid`) and answers with `d_rdata`/`d_ready` after one wait state. It holds a free-running 64-bit cycle counter and a one-shot compare register. On a compare match it raises a level interrupt, which is wired into the core's `interrupt_sources`.

## Interface
- `TIME_ADDR`, default 64'hFFFF001C: read returns the cycle counter; write loads the compare value and arms the timer.
- `ACK_ADDR`, default 64'hFFFF006C: write clears the pending interrupt; read returns 0.
- `clock`  input  1  sole clock.
- `reset`  input  1  synchronous, active-high.
- `d_addr`  input  64  request address from the core.
- `d_wdata`  input  64  store data from the core.
- `d_store_type`  input  mem_store_type_t  zero means read; any non-zero value means write.
- `d_valid`  input  1  core request strobe.
- `d_rdata`  output  64  read data, valid when `d_ready` is high.
- `d_ready`  output  1  one-cycle response pulse for a selected request.
- `hit`  output  1  combinational: `d_valid` and (`d_addr`==`TIME_ADDR` or `d_addr`==`ACK_ADDR`). Used by the bus mux to pick this block's `d_rdata`/`d_ready`.
- `timer_interrupt`  output  1  pending-interrupt level.

## Operation
- Registers:
  - `cycle[63:0]`: increments every cycle; wraps from 2^64-1 to 0.
  - `compare[63:0]`, `armed`, `pending`.
- The address decode is a full 64-bit equality compare. Unselected addresses produce no response: `d_ready` stays 0 and no state changes.
- The handshake FSM has two states, IDLE and RESP.
  - IDLE: if `hit`, accept the request at the clock edge and go to RESP. Otherwise stay in IDLE.
  - RESP: `d_ready`=1 and `d_rdata` holds the response. Return to IDLE unconditionally. `d_valid` is ignored in RESP, since the core still holds the same request during that cycle.
- Actions at the acceptance edge:
  - Read `TIME_ADDR`: `d_rdata` is loaded with the pre-increment value of `cycle` at that edge.
  - Write `TIME_ADDR`: `compare` is loaded with `d_wdata`, and `armed` is set to 1.
  - Write `ACK_ADDR`: `pending` is cleared to 0.
  - Read `ACK_ADDR`: `d_rdata` is loaded with 0.
  - Writes load `d_rdata` with 0.
- Match: in any cycle where `armed` && `cycle`==`compare`, at the next edge `pending`=1 and `armed`=0 (one-shot).
- `timer_interrupt` = `pending`.
- Simultaneous events:
  - A match and an ACK write in the same cycle: `pending` ends at 1. Set wins, so no event is lost.
  - A match and a `TIME_ADDR` write in the same cycle: the match uses the old `compare` and may set `pending`. The write still loads the new `compare` and leaves `armed`=1.
  - A compare value already in the past fires only after `cycle` wraps around to it.

## Timing
- Reset values: `cycle`=0, `compare`=0, `armed`=0, `pending`=0, FSM=IDLE, `d_ready`=0, `d_rdata`=0, `timer_interrupt`=0.
- `hit` is combinational. `d_ready`, `d_rdata` and `timer_interrupt` are registered.
- Latency: a request accepted at edge N gets `d_ready`=1 during the cycle after edge N. The core stalls exactly one cycle per access.
- Back-to-back selected requests take 2 cycles each: accept, then respond.
- `timer_interrupt` rises on the edge after the match cycle. It stays high until the edge that accepts an ACK write.
- Reset asserted while in RESP: the next cycle is IDLE with `d_ready`=0, and the in-flight response is dropped.

## Test plan
- Reset, then read `TIME_ADDR` accepted at the edge where `cycle`=5 → `d_ready`=1 for exactly one cycle, `d_rdata`=5; `d_ready`=0 on the following cycle.
- Write `compare`=20 when `cycle`=10 → `timer_interrupt` rises on the edge after `cycle`==20 and stays high for 50 cycles. A write to `ACK_ADDR` then clears it at the acceptance edge, and it does not re-fire at the next wrap-free cycles (one-shot).
- Request to address 64'hFFFF0020 with `d_valid`=1 → `hit`=0, `d_ready` stays 0, `compare`/`pending` unchanged.
- ACK write accepted in the same cycle as a match → `timer_interrupt`=1 afterwards.
- Force `cycle` near 2^64-1 (via compare write of 1 with `cycle` preloaded by a test hook or a long run with a reduced-width build), then observe wrap → `cycle` goes 2^64-1 to 0, and the match at 1 fires.
- Assert `reset` during RESP → next cycle `d_ready`=0, `d_rdata`=0, `armed`=0, `timer_interrupt`=0.
